// File: rtl/mem_requester.sv
`default_nettype none
// ============================================================================
// Module      : mem_requester
// Description : Single-outstanding initiator for the memory request/busy
//               protocol. Takes read/write commands on a valid/ready port,
//               drives memReq/memWr/memAddr/memDataIn, watches memBusyOut and
//               returns one response per command (timeout -> rsp_err).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_requester #(
  parameter int MEM_ADDR_SIZE = 32,
  parameter int MEM_WORD_SIZE = 8,
  parameter int TIMEOUT       = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  // client command channel
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_wr,
  input  logic [MEM_ADDR_SIZE-1:0] cmd_addr,
  input  logic [MEM_WORD_SIZE-1:0] cmd_wdata,
  // client response channel
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [MEM_WORD_SIZE-1:0] rsp_rdata,
  output logic                     rsp_err,
  output logic [15:0]              txn_count,
  // memory port
  output logic                     memReq,
  output logic                     memWr,
  output logic [MEM_ADDR_SIZE-1:0] memAddr,
  output logic [MEM_WORD_SIZE-1:0] memDataIn,
  input  logic                     memBusyOut,
  input  logic [MEM_WORD_SIZE-1:0] memDataOut
);

  // Timer value at which the stalled transaction is abandoned.
  localparam logic [15:0] C_TIMER_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t                     state_q,       state_d;
  logic                       mem_req_q,     mem_req_d;
  logic                       mem_wr_q,      mem_wr_d;
  logic [MEM_ADDR_SIZE-1:0]   mem_addr_q,    mem_addr_d;
  logic [MEM_WORD_SIZE-1:0]   mem_data_in_q, mem_data_in_d;
  logic                       rsp_valid_q,   rsp_valid_d;
  logic [MEM_WORD_SIZE-1:0]   rsp_rdata_q,   rsp_rdata_d;
  logic                       rsp_err_q,     rsp_err_d;
  logic [15:0]                txn_count_q,   txn_count_d;
  logic [15:0]                timer_q,       timer_d;

  // State and datapath registers; reset also drops memReq asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      mem_req_q     <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      txn_count_q   <= 16'd0;
      timer_q       <= 16'd0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_wr_q      <= mem_wr_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      txn_count_q   <= txn_count_d;
      timer_q       <= timer_d;
    end
  end

  // Next-state logic: issue, wait for busy high then low, respond, or time out.
  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_wr_d      = mem_wr_q;
    mem_addr_d    = mem_addr_q;
    mem_data_in_d = mem_data_in_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    txn_count_d   = txn_count_q;
    timer_d       = timer_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          mem_wr_d      = cmd_wr;
          mem_addr_d    = cmd_addr;
          mem_data_in_d = cmd_wdata;
          mem_req_d     = 1'b1;
          timer_d       = 16'd0;
          state_d       = S_REQ;
        end
      end

      S_REQ: begin
        timer_d = timer_q + 16'd1;
        // Seeing busy is only progress, not completion, so the timeout
        // still takes priority here; this keeps the equality test exact.
        if (timer_q == C_TIMER_LAST) begin
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = S_RESP;
        end else if (memBusyOut) begin
          // Drop the strobe now so the memory never sees a second request.
          mem_req_d = 1'b0;
          state_d   = S_WAIT;
        end
      end

      S_WAIT: begin
        timer_d = timer_q + 16'd1;
        if (!memBusyOut) begin
          // Completion wins over a coincident timeout.
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = mem_wr_q ? '0 : memDataOut;
          txn_count_d = txn_count_q + 16'd1;
          state_d     = S_RESP;
        end else if (timer_q == C_TIMER_LAST) begin
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = S_RESP;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign txn_count = txn_count_q;
  assign memReq    = mem_req_q;
  assign memWr     = mem_wr_q;
  assign memAddr   = mem_addr_q;
  assign memDataIn = mem_data_in_q;

endmodule
`default_nettype wire

// File: doc/mem_requester.md
# mem_requester

Initiator for the dummy memory request/busy protocol. Accepts single read or write commands from a client over a valid/ready interface and drives the memory port's `memReq`/`memWr`/`memAddr`/`memDataIn`. It tracks `memBusyOut`, captures read data and returns one response per command, with a timeout error if the memory stalls. It sits between a CPU/DMA client and any memory that speaks this protocol.

## Interface
- MEM_ADDR_SIZE, 32, address width
- MEM_WORD_SIZE, 8, data word width
- TIMEOUT, 64, maximum cycles in REQ+WAIT before an error response; legal range 4..65535
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  client command present
- cmd_ready  out  1  high only in IDLE
- cmd_wr  in  1  1 = write, 0 = read
- cmd_addr  in  MEM_ADDR_SIZE  command address
- cmd_wdata  in  MEM_WORD_SIZE  write data
- rsp_valid  out  1  response present; held until rsp_ready
- rsp_ready  in  1  client accepts response
- rsp_rdata  out  MEM_WORD_SIZE  read data; 0 for writes and errors
- rsp_err  out  1  transaction timed out
- txn_count  out  16  successful transactions, wraps 0xFFFF→0
- memReq  out  1  request strobe to memory
- memWr  out  1  write enable to memory
- memAddr  out  MEM_ADDR_SIZE  address to memory
- memDataIn  out  MEM_WORD_SIZE  write data to memory
- memBusyOut  in  1  memory busy
- memDataOut  in  MEM_WORD_SIZE  memory read data, valid once memBusyOut falls

## Operation
- States: IDLE, REQ, WAIT, RESP. Reset enters IDLE.
- Reset values: memReq=0, memWr=0, memAddr=0, memDataIn=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, txn_count=0. cmd_ready=1, because it is derived from IDLE.
- IDLE: on cmd_valid&cmd_ready, register cmd_wr/addr/wdata onto memWr/memAddr/memDataIn. Set memReq=1, clear the timeout counter, go to REQ.
- REQ: when memBusyOut=1 is sampled, clear memReq and go to WAIT. memReq must be low before the memory returns to its idle state, so it is never seen as a second request.
- WAIT: when memBusyOut=0 is sampled, go to RESP with rsp_valid=1 and rsp_err=0. On a read, rsp_rdata=memDataOut; on a write, rsp_rdata=0. txn_count increments on this edge.
- memWr, memAddr and memDataIn are held stable from entry to REQ until leaving WAIT. The memory samples them while busy.
- Timeout: a 16-bit counter increments every cycle in REQ or WAIT. If the counter equals TIMEOUT-1 and no completion condition is met, go to RESP with rsp_err=1 and rsp_rdata=0, and clear memReq. txn_count does not change.
- RESP: hold the rsp_* outputs until rsp_valid&rsp_ready, then clear rsp_valid and go to IDLE. rsp_err and rsp_rdata keep their values until the next response. No command is accepted in RESP.
- If the completion condition and the timeout hit on the same edge, completion wins.
- Reset mid-transaction drops memReq asynchronously. Any in-flight response is lost, and the memory is resynchronised by its own reset.

## Timing
- Command accepted at edge E0. memReq is high after E0.
- With a zero-latency memory:
  - busy rises at E1
  - the requester sees busy at E2 and drops memReq
  - the memory drops busy at E2
  - the requester sees busy low at E3, so rsp_valid is high after E3
- Minimum command-to-response latency is 3 cycles. With rsp_ready tied high, rsp_valid lasts 1 cycle, IDLE follows, and the next accept is at E5 at the earliest (5-cycle throughput).
- Memory latency extends WAIT one-for-one. The requester depends only on memBusyOut levels.
- Timeout response appears TIMEOUT edges after E0.

## Test plan
- Reset, then write addr=3 data=0xA5. Expect memReq high for 2 cycles, memWr=1 and memAddr=3 held through WAIT, rsp_valid after E3 with rsp_err=0 and rsp_rdata=0, txn_count=1.
- Read addr=3 after that write. Expect rsp_rdata=0xA5, rsp_err=0, txn_count=2.
- rsp_ready held low for 5 cycles. Expect rsp_valid and rsp_rdata stable and cmd_ready=0 throughout, then IDLE on the edge after rsp_ready rises.
- Memory stub never raises busy, TIMEOUT=8. Expect rsp_valid with rsp_err=1 and rsp_rdata=0 exactly 8 edges after accept, memReq=0 in RESP, txn_count unchanged.
- Busy stuck high after rising, TIMEOUT=8. Expect memReq dropped once busy is seen and an error response at edge 8.
- Assert reset while in WAIT. Expect memReq, rsp_valid and txn_count at 0 immediately. cmd_ready=1, and a fresh read of addr 3 then completes normally.
